// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch front end.
// Contents: default widths, the bubble encoding and the fetch FSM state type.
package fetch_pkg;

    localparam int unsigned XLEN_DEFAULT    = 32;
    localparam int unsigned PC_STEP_DEFAULT = 4;

    // Bubble loaded into IF/ID (opcode 5'b00000)
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_redirect_unit_if_id_reg.sv
// IF/ID pipeline register with load / hold / bubble controls.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   load                 capture instrIn/pcIn as a real instruction
//   bubble               replace contents with NOP_INSTR, valid_d=0 (wins over load)
//   instrIn, pcIn        incoming instruction word and its PC
//   instr_d, pc_d        registered instruction and PC
//   pc_plus_d            registered pcIn + PC_STEP
//   valid_d              register holds a real instruction
// Neither load nor bubble: contents held.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int unsigned      XLEN      = XLEN_DEFAULT,
    parameter int unsigned      PC_STEP   = PC_STEP_DEFAULT,
    parameter logic [XLEN-1:0]  NOP_INSTR = XLEN'(NOP_INSTR_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            bubble,
    input  logic [XLEN-1:0] instrIn,
    input  logic [XLEN-1:0] pcIn,
    output logic [XLEN-1:0] instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus_d,
    output logic            valid_d
);

    localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

    // Bubble only clears instruction/valid; PC fields keep their last value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_d   <= NOP_INSTR;
            pc_d      <= '0;
            pc_plus_d <= '0;
            valid_d   <= 1'b0;
        end else if (bubble) begin
            instr_d   <= NOP_INSTR;
            valid_d   <= 1'b0;
        end else if (load) begin
            instr_d   <= instrIn;
            pc_d      <= pcIn;
            pc_plus_d <= pcIn + STEP;
            valid_d   <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_redirect_unit.sv
// Fetch front end: owns the PC, fetches over a ready/valid instruction-memory
// handshake and drives the IF/ID register, applying select_pc / flush / stall
// from the hazard unit cycle-exactly (priority select_pc > flush > stall).
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   select_pc, branch_target       redirect fetch to branch_target
//   flush                          bubble into IF/ID
//   stall                          freeze PC and IF/ID
//   imem_req, imem_addr            fetch request / address (held until imem_valid)
//   imem_rdata, imem_valid         fetch response
//   instr_d, pc_d, pc_plus_d       IF/ID contents
//   valid_d                        IF/ID holds a real instruction
//   fetch_busy                     waiting on memory
// Optional (macro FETCH_PERF_CNT_EN): redirect_cnt, stall_cnt saturating counters.
module fetch_redirect_unit
    import fetch_pkg::*;
#(
    parameter int unsigned      XLEN      = XLEN_DEFAULT,
    parameter logic [XLEN-1:0]  RESET_PC  = '0,
    parameter int unsigned      PC_STEP   = PC_STEP_DEFAULT,
    parameter logic [XLEN-1:0]  NOP_INSTR = XLEN'(NOP_INSTR_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            select_pc,
    input  logic [XLEN-1:0] branch_target,
    input  logic            flush,
    input  logic            stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_valid,
    output logic [XLEN-1:0] instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus_d,
    output logic            valid_d,
    output logic            fetch_busy
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]     redirect_cnt,
    output logic [15:0]     stall_cnt
`endif
);

    localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

    fetch_state_t    state, stateNext;
    logic [XLEN-1:0] pc, pcNext;
    logic            holdValid, holdValidNext;
    logic [XLEN-1:0] holdData, holdDataNext;
    logic            pendValid, pendValidNext;
    logic [XLEN-1:0] pendTarget, pendTargetNext;
    logic            gotRsp;
    logic            ifLoad, ifBubble;
    logic [XLEN-1:0] ifInstr;

    // No request while a stalled word is parked: that fetch is already complete
    assign imem_req   = (state != BOOT) && !holdValid;
    assign imem_addr  = pc;
    assign fetch_busy = (state == WAIT);
    assign gotRsp     = imem_req && imem_valid;

    // State, PC, hold buffer and pending redirect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            holdValid  <= 1'b0;
            holdData   <= '0;
            pendValid  <= 1'b0;
            pendTarget <= '0;
        end else begin
            state      <= stateNext;
            pc         <= pcNext;
            holdValid  <= holdValidNext;
            holdData   <= holdDataNext;
            pendValid  <= pendValidNext;
            pendTarget <= pendTargetNext;
        end
    end

    // Next state and IF/ID control
    always_comb begin
        stateNext      = state;
        pcNext         = pc;
        holdValidNext  = holdValid;
        holdDataNext   = holdData;
        pendValidNext  = pendValid;
        pendTargetNext = pendTarget;
        ifLoad         = 1'b0;
        ifBubble       = 1'b0;
        ifInstr        = imem_rdata;

        // Handshake sequencing is independent of the hazard controls
        unique case (state)
            BOOT:    stateNext = FETCH;
            FETCH:   stateNext = (imem_req && !imem_valid) ? WAIT : FETCH;
            WAIT:    stateNext = imem_valid ? FETCH : WAIT;
            default: stateNext = BOOT;
        endcase

        if (select_pc) begin
            ifBubble      = 1'b1;
            holdValidNext = 1'b0;
            // An outstanding request must complete first; remember the target
            if (imem_req && !imem_valid) begin
                pendValidNext  = 1'b1;
                pendTargetNext = branch_target;
            end else begin
                pcNext        = branch_target;
                pendValidNext = 1'b0;
            end
        end else if (gotRsp && pendValid) begin
            // Response for the squashed path: drop it and take the saved target
            pcNext        = pendTarget;
            pendValidNext = 1'b0;
            ifBubble      = flush || !stall;
        end else if (flush) begin
            ifBubble      = 1'b1;
            holdValidNext = 1'b0;
            if (!stall && (gotRsp || holdValid)) begin
                pcNext = pc + STEP;
            end
        end else if (stall) begin
            if (gotRsp) begin
                holdValidNext = 1'b1;
                holdDataNext  = imem_rdata;
            end
        end else if (holdValid) begin
            ifLoad        = 1'b1;
            ifInstr       = holdData;
            pcNext        = pc + STEP;
            holdValidNext = 1'b0;
        end else if (gotRsp) begin
            ifLoad = 1'b1;
            pcNext = pc + STEP;
        end else begin
            ifBubble = 1'b1;
        end
    end

    if_id_reg #(
        .XLEN      (XLEN),
        .PC_STEP   (PC_STEP),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ifLoad),
        .bubble    (ifBubble),
        .instrIn   (ifInstr),
        .pcIn      (pc),
        .instr_d   (instr_d),
        .pc_d      (pc_d),
        .pc_plus_d (pc_plus_d),
        .valid_d   (valid_d)
    );

`ifdef FETCH_PERF_CNT_EN
    // Saturating event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_cnt <= '0;
            stall_cnt    <= '0;
        end else begin
            if (select_pc && (redirect_cnt != 16'hFFFF)) begin
                redirect_cnt <= redirect_cnt + 16'd1;
            end
            if (stall && !select_pc && !flush && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Bench for fetch_redirect_unit: directed scenarios with literal expectations,
// then randomized hazard controls and memory latency against a behavioural model.
module tb_fetch_redirect_unit;

    localparam logic [31:0] STEP     = 32'd4;
    localparam logic [31:0] RST_PC   = 32'h0;
    localparam logic [31:0] NOP      = 32'h0;

    logic        clk;
    logic        rst_n;
    logic        select_pc;
    logic [31:0] branch_target;
    logic        flush;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus_d;
    logic        valid_d;
    logic        fetch_busy;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] redirect_cnt;
    logic [15:0] stall_cnt;
`endif

    int errors;
    int checks;

    // Model state: what the front end must look like after each edge
    logic        mBooted;
    logic [31:0] mPc;
    logic        mBufFull;
    logic [31:0] mBufWord;
    logic        mPendFull;
    logic [31:0] mPendTgt;
    logic        mBusy;
    logic [31:0] mInstr;
    logic [31:0] mPcD;
    logic [31:0] mPcPlusD;
    logic        mValidD;
    int          mRedir;
    int          mStalls;

    fetch_redirect_unit #(
        .XLEN      (32),
        .RESET_PC  (32'h0),
        .PC_STEP   (4),
        .NOP_INSTR (32'h0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .select_pc     (select_pc),
        .branch_target (branch_target),
        .flush         (flush),
        .stall         (stall),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_valid    (imem_valid),
        .instr_d       (instr_d),
        .pc_d          (pc_d),
        .pc_plus_d     (pc_plus_d),
        .valid_d       (valid_d),
        .fetch_busy    (fetch_busy)
`ifdef FETCH_PERF_CNT_EN
        ,
        .redirect_cnt  (redirect_cnt),
        .stall_cnt     (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents as a pure function of the address (never zero)
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, ~a[17:2]};
    endfunction

    assign imem_rdata = memWord(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mBooted   = 1'b0;
        mPc       = RST_PC;
        mBufFull  = 1'b0;
        mBufWord  = '0;
        mPendFull = 1'b0;
        mPendTgt  = '0;
        mBusy     = 1'b0;
        mInstr    = NOP;
        mPcD      = '0;
        mPcPlusD  = '0;
        mValidD   = 1'b0;
        mRedir    = 0;
        mStalls   = 0;
    endtask

    // One clock edge of the front end, stated in terms of what happens to the
    // fetched word, the PC and IF/ID under the current controls
    task automatic modelStep();
        logic        req, resp, haveWord, redirect, frozen, deliver, bufAfter;
        logic [31:0] fetched, word, tgtNow;
        if (!rst_n) begin
            modelReset();
            return;
        end
        req      = mBooted && !mBufFull;
        resp     = req && imem_valid;
        fetched  = memWord(mPc);
        haveWord = mBufFull || (resp && !mPendFull);
        word     = mBufFull ? mBufWord : fetched;
        redirect = select_pc ? !(req && !imem_valid) : (resp && mPendFull);
        tgtNow   = select_pc ? branch_target : mPendTgt;
        frozen   = !select_pc && !flush && stall;
        deliver  = !select_pc && !flush && !stall && haveWord;
        bufAfter = frozen && (mBufFull || (resp && !mPendFull));

        if (deliver) begin
            mInstr   = word;
            mPcD     = mPc;
            mPcPlusD = mPc + STEP;
            mValidD  = 1'b1;
        end else if (!frozen) begin
            mInstr  = NOP;
            mValidD = 1'b0;
        end

        if (frozen && !mBufFull && resp && !mPendFull) mBufWord = fetched;
        mBufFull = bufAfter;

        if (redirect) mPc = tgtNow;
        else if (!select_pc && !stall && haveWord) mPc = mPc + STEP;

        if (select_pc && req && !imem_valid) begin
            mPendFull = 1'b1;
            mPendTgt  = branch_target;
        end else if (redirect) begin
            mPendFull = 1'b0;
        end

        mBusy   = req && !imem_valid;
        mBooted = 1'b1;
        if (select_pc && mRedir < 65535) mRedir++;
        if (frozen && mStalls < 65535) mStalls++;
    endtask

    // Every-cycle comparison of all outputs against the model
    task automatic checkAll();
        chk("imem_req",   32'(imem_req),   32'(mBooted && !mBufFull));
        chk("imem_addr",  imem_addr,       mPc);
        chk("fetch_busy", 32'(fetch_busy), 32'(mBusy));
        chk("valid_d",    32'(valid_d),    32'(mValidD));
        chk("instr_d",    instr_d,         mInstr);
        chk("pc_d",       pc_d,            mPcD);
        chk("pc_plus_d",  pc_plus_d,       mPcPlusD);
`ifdef FETCH_PERF_CNT_EN
        chk("redirect_cnt", 32'(redirect_cnt), 32'(mRedir));
        chk("stall_cnt",    32'(stall_cnt),    32'(mStalls));
`endif
    endtask

    // Drive one cycle of inputs, let the edge happen, then compare just after it
    task automatic step(input logic r, input logic sel, input logic [31:0] tgt,
                        input logic fl, input logic st, input logic iv);
        rst_n         = r;
        select_pc     = sel;
        branch_target = tgt;
        flush         = fl;
        stall         = st;
        imem_valid    = iv;
        if (!r) modelReset();
        @(posedge clk);
        modelStep();
        #1;
        checkAll();
    endtask

    logic        rR, rSel, rFl, rSt, rIv;
    logic [31:0] rTgt;

    initial begin
        errors = 0;
        checks = 0;
        modelReset();

        // Reset values
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("rst_req",    32'(imem_req), 32'h0);
        chk("rst_valid",  32'(valid_d),  32'h0);
        chk("rst_instr",  instr_d,       32'h0);
        chk("rst_pc_d",   pc_d,          32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Release: one BOOT cycle, then sequential fetch 0, 4, 8
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("boot_req",   32'(imem_req), 32'h1);
        chk("boot_addr",  imem_addr,     32'h0);
        chk("boot_valid", 32'(valid_d),  32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("seq_addr4",  imem_addr,     32'h4);
        chk("seq_valid",  32'(valid_d),  32'h1);
        chk("seq_pc_d0",  pc_d,          32'h0);
        chk("seq_plus4",  pc_plus_d,     32'h4);
        chk("seq_instr0", instr_d,       memWord(32'h0));
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("seq_addr8",  imem_addr,     32'h8);

        // Branch redirect to 0x5c
        step(1'b1, 1'b1, 32'h5c, 1'b0, 1'b0, 1'b1);
        chk("br_addr",    imem_addr,     32'h5c);
        chk("br_bubble",  32'(valid_d),  32'h0);
        chk("br_nop",     instr_d,       32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("br_pc_d",    pc_d,          32'h5c);
        chk("br_plus",    pc_plus_d,     32'h60);
        chk("br_valid",   32'(valid_d),  32'h1);

        // Three stall cycles with data arriving: frozen, word parked
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
            chk("stl_pc_d",  pc_d,      32'h5c);
            chk("stl_addr",  imem_addr, 32'h60);
            chk("stl_instr", instr_d,   memWord(32'h5c));
        end
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("rel_pc_d",   pc_d,          32'h60);
        chk("rel_instr",  instr_d,       memWord(32'h60));
        chk("rel_addr",   imem_addr,     32'h64);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("rel2_pc_d",  pc_d,          32'h64);
        chk("rel2_addr",  imem_addr,     32'h68);

        // Memory wait with redirect on the second wait cycle
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("w1_busy",    32'(fetch_busy), 32'h1);
        chk("w1_addr",    imem_addr,       32'h68);
        step(1'b1, 1'b1, 32'h60, 1'b0, 1'b0, 1'b0);
        chk("w2_busy",    32'(fetch_busy), 32'h1);
        chk("w2_addr",    imem_addr,       32'h68);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("w3_busy",    32'(fetch_busy), 32'h1);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("w4_busy",    32'(fetch_busy), 32'h0);
        chk("w4_addr",    imem_addr,       32'h60);
        chk("w4_drop",    32'(valid_d),    32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("w5_pc_d",    pc_d,            32'h60);
        chk("w5_valid",   32'(valid_d),    32'h1);

        // Stall and flush together: bubble, PC held
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        chk("sf_valid",   32'(valid_d),  32'h0);
        chk("sf_instr",   instr_d,       32'h0);
        chk("sf_addr",    imem_addr,     32'h64);

        // Reset asserted while waiting on memory
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("rw_busy",    32'(fetch_busy), 32'h1);
        rst_n = 1'b0;
        modelReset();
        #1;
        chk("rw_req",     32'(imem_req),   32'h0);
        chk("rw_busy0",   32'(fetch_busy), 32'h0);
        chk("rw_valid",   32'(valid_d),    32'h0);
        chk("rw_addr",    imem_addr,       32'h0);
        checkAll();
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("rw_restart", imem_addr,       32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("rw_pc_d",    pc_d,            32'h0);
        chk("rw_addr4",   imem_addr,       32'h4);

        // Randomized controls and memory latency, including PC wrap targets
        for (int i = 0; i < 4000; i++) begin
            rR   = ($urandom_range(0, 499) != 0);
            rSel = ($urandom_range(0, 9) == 0);
            rFl  = ($urandom_range(0, 9) == 0);
            rSt  = ($urandom_range(0, 4) == 0);
            rIv  = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 7) == 0)
                rTgt = 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
            else
                rTgt = 32'($urandom_range(0, 1023)) << 2;
            step(rR, rSel, rTgt, rFl, rSt, rIv);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_redirect_unit.md
Name: fetch_redirect_unit

Overview:
Consumer end of the hazard-control signals (select_pc, flush, stall). Owns the program counter, fetches from instruction memory with a ready/valid handshake, and drives the IF/ID pipeline register. It applies branch redirects, inserts bubbles on flush and freezes the front end on stall, so the hazard unit's outputs take effect cycle-exactly.

Parameters:
XLEN, 32, width of PC, branch target and instruction words
RESET_PC, 32'h0, first fetch address after reset
PC_STEP, 4, PC increment per sequential fetch
NOP_INSTR, 32'h0, bubble encoding loaded into IF/ID (opcode 5'b00000)

Ports:
clk  in  1  processor clock, rising edge
rst_n  in  1  asynchronous active-low reset
select_pc  in  1  1 = redirect fetch to branch_target (from hazard unit)
branch_target  in  XLEN  resolved branch target from EX
flush  in  1  1 = replace IF/ID contents with bubble
stall  in  1  1 = hold PC and IF/ID
imem_req  out  1  fetch request; held until imem_valid
imem_addr  out  XLEN  fetch address; stable while imem_req && !imem_valid
imem_rdata  in  XLEN  instruction returned
imem_valid  in  1  imem_rdata valid this cycle; may be same cycle as request
instr_d  out  XLEN  IF/ID instruction
pc_d  out  XLEN  IF/ID PC
pc_plus_d  out  XLEN  IF/ID PC + PC_STEP
valid_d  out  1  IF/ID holds a real instruction
fetch_busy  out  1  waiting on memory (state WAIT)

Behaviour:
- Reset (async, any state): pc=RESET_PC, state=BOOT, imem_req=0, instr_d=NOP_INSTR, pc_d=0, pc_plus_d=0, valid_d=0, hold buffer empty, pending redirect cleared.
- FSM: BOOT -> FETCH unconditionally next cycle (no request in BOOT). FETCH: imem_req=1, imem_addr=pc; if !imem_valid -> WAIT. WAIT: request and address held; on imem_valid -> FETCH.
- Zero-wait memory: one instruction per cycle; IF/ID loads at edge after imem_valid; pc += PC_STEP (wraps mod 2^XLEN).
- Priority per cycle: select_pc > flush > stall > normal.
- select_pc=1: pc <= branch_target next edge; IF/ID <= bubble (valid_d=0, instr_d=NOP_INSTR); current response discarded. In WAIT with no imem_valid: save target in pending register, keep request; when imem_valid arrives, drop that data, pc <= saved target, go FETCH. Later select_pc overwrites pending target.
- flush=1 (no select_pc): IF/ID <= bubble; pc advances normally if a response was consumed.
- stall=1 alone: pc, IF/ID, imem_addr held. A response arriving during stall is captured in a 1-entry hold buffer; on first non-stall cycle IF/ID loads from the buffer, pc advances, no new memory data used that cycle. select_pc or flush empties the buffer.
- stall and flush together: flush wins (bubble), pc held.
- pc_plus_d = pc_d + PC_STEP, registered with pc_d.
- fetch_busy = (state==WAIT).

Optional Feature:
FETCH_PERF_CNT_EN: defined -> adds outputs redirect_cnt[15:0] and stall_cnt[15:0]; saturating counters incremented on each select_pc cycle and each stall-only cycle; reset to 0. Undefined -> ports and logic absent; core behaviour identical.

Decomposition:
- Package fetch_pkg: XLEN default, NOP_INSTR, fetch_state_t enum {BOOT, FETCH, WAIT}.
- Sub-module if_id_reg: IF/ID register with load/hold/bubble controls and async active-low reset; fetch_redirect_unit owns PC, FSM, hold buffer, pending redirect.

Test Plan:
- Reset release, imem_valid tied 1 -> BOOT one cycle, then imem_addr 0x0,0x4,0x8; valid_d rises 2 cycles after rst_n.
- select_pc=1, branch_target=32'h5c for one cycle -> next imem_addr 0x5c, valid_d=0 one cycle, then pc_d=0x5c with pc_plus_d=0x60.
- stall=1 three cycles with imem_valid=1 -> pc_d, instr_d, imem_addr frozen; hold buffer loaded; after release IF/ID gets buffered word, no duplicate/skip.
- imem_valid low 3 cycles, select_pc=1 (target 0x60) on 2nd wait cycle -> returned word dropped, next request address 0x60, fetch_busy high exactly 3 cycles.
- stall=1 and flush=1 same cycle -> valid_d=0, instr_d=0x0, pc held.
- rst_n asserted during WAIT -> outputs immediately at reset values, fetch restarts at RESET_PC.
